// File: rtl/nabp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nabp_pkg
//  Description : Shared types and constants for the NABP back-projection
//                blocks: image-RAM address generator state encoding,
//                default partition count and image address width.
//  Revision    : 1.0 - initial release
// ============================================================================
package nabp_pkg;

    // Address generator state encoding (2-bit, value 3 is illegal)
    typedef enum logic [1:0] {
        READY      = 2'd0,
        DELAY      = 2'd1,
        ADDRESSING = 2'd2
    } nabp_state_t;

    localparam int c_nabp_partitions  = 4;
    localparam int c_nabp_image_words = 1024;
    localparam int c_nabp_addr_w      = $clog2(c_nabp_image_words);

    // Counter width able to hold n-1, never narrower than one bit
    function automatic int nabp_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : nabp_pkg
`default_nettype wire

// File: rtl/def_delay_counter.sv
`default_nettype none
// ============================================================================
//  Module      : def_delay_counter
//  Description : Loadable down-counter with zero flag, used to align the PE
//                domino chain with the partitions.
//  Ports       : clk      - clock
//                rst      - synchronous active-high reset (loads LOAD_VAL)
//                i_load   - reload LOAD_VAL this cycle
//                i_dec    - decrement by one this cycle
//                o_zero   - counter value equals zero
//  Revision    : 1.0 - initial release
// ============================================================================
module def_delay_counter #(
    parameter int              CNT_W    = 2,
    parameter logic [CNT_W-1:0] LOAD_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= LOAD_VAL;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule : def_delay_counter
`default_nettype wire

// File: rtl/def.sv
`default_nettype none
// ============================================================================
//  Module      : def
//  Description : Image-RAM address generator. On a kick it waits
//                NO_OF_PARTITIONS cycles, then walks ir_addr from 0 to
//                IMAGE_WORDS-1, advancing only on ir_enable, and returns to
//                READY after the last address.
//  Ports       : clk           - clock
//                reset         - synchronous active-high reset
//                ir_kick       - start request (READY only)
//                ir_enable     - address advance enable (ADDRESSING only)
//                ir_addr       - current image RAM address (registered)
//                ir_addr_valid - address consumed this cycle
//                busy          - in DELAY or ADDRESSING
//                done          - pulse with the last consumed address
//  Revision    : 1.0 - initial release
// ============================================================================
module def
    import nabp_pkg::*;
#(
    parameter int NO_OF_PARTITIONS = c_nabp_partitions,
    parameter int IMAGE_WORDS      = c_nabp_image_words,
    parameter int ADDR_W           = $clog2(IMAGE_WORDS),
    parameter int CNT_W            = nabp_cnt_w(NO_OF_PARTITIONS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ir_kick,
    input  logic              ir_enable,
    output logic [ADDR_W-1:0] ir_addr,
    output logic              ir_addr_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(IMAGE_WORDS - 1);
    localparam logic [CNT_W-1:0]  c_delay_load = CNT_W'(NO_OF_PARTITIONS - 1);

    nabp_state_t       r_state;
    nabp_state_t       w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic              w_in_ready;
    logic              w_in_delay;
    logic              w_in_addr;
    logic              w_delay_done;
    logic              w_addressing_done;

    assign w_in_ready = (r_state == READY);
    assign w_in_delay = (r_state == DELAY);
    assign w_in_addr  = (r_state == ADDRESSING);

    // Reloaded on every READY cycle so each run gets the full delay
    def_delay_counter #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (c_delay_load)
    ) u_delay_counter (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_in_ready),
        .i_dec  (w_in_delay),
        .o_zero (w_delay_done)
    );

    assign w_addressing_done = w_in_addr & ir_enable & (r_addr == c_last_addr);

    always_comb begin
        w_next_state = READY;
        case (r_state)
            READY:      w_next_state = ir_kick           ? DELAY      : READY;
            DELAY:      w_next_state = w_delay_done      ? ADDRESSING : DELAY;
            ADDRESSING: w_next_state = w_addressing_done ? READY      : ADDRESSING;
            default:    w_next_state = READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= READY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Address counter: clears on the last address so the next run starts at 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
        end else if (w_addressing_done) begin
            r_addr <= '0;
        end else if (w_in_addr && ir_enable) begin
            r_addr <= r_addr + ADDR_W'(1);
        end else if (!w_in_addr) begin
            r_addr <= '0;
        end
    end

    assign ir_addr       = r_addr;
    assign ir_addr_valid = w_in_addr & ir_enable;
    assign busy          = w_in_delay | w_in_addr;
    assign done          = w_addressing_done;

endmodule : def
`default_nettype wire

// File: tb/tb_def.sv
`default_nettype none
// ============================================================================
//  Module      : tb_def
//  Description : Self-checking bench for the image-RAM address generator.
//                Expected addresses are queued when an accepted kick is
//                driven and popped whenever the DUT reports a consumed
//                address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_def;

    localparam int c_w4 = 16;
    localparam int c_w1 = 4;

    logic       clk;
    logic       reset4, kick4, en4;
    logic [3:0] addr4;
    logic       valid4, busy4, done4;
    logic       reset1, kick1, en1;
    logic [1:0] addr1;
    logic       valid1, busy1, done1;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    def #(.NO_OF_PARTITIONS(4), .IMAGE_WORDS(c_w4)) u_dut4 (
        .clk           (clk),
        .reset         (reset4),
        .ir_kick       (kick4),
        .ir_enable     (en4),
        .ir_addr       (addr4),
        .ir_addr_valid (valid4),
        .busy          (busy4),
        .done          (done4)
    );

    def #(.NO_OF_PARTITIONS(1), .IMAGE_WORDS(c_w1)) u_dut1 (
        .clk           (clk),
        .reset         (reset1),
        .ir_kick       (kick1),
        .ir_enable     (en1),
        .ir_addr       (addr1),
        .ir_addr_valid (valid1),
        .busy          (busy1),
        .done          (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int k = 0; k < c_w4; k++) exp_q.push_back(k);
    endtask

    // Scoreboard: every consumed address must be the next expected one,
    // and done must accompany exactly the last address of a frame.
    always @(negedge clk) begin
        if (reset4 === 1'b0) begin
            if (valid4 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_addr", 32'(addr4), 32'hFFFF_FFFF);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("sb_addr", 32'(addr4), 32'(e));
                    check("sb_done", 32'(done4), 32'(e == c_w4 - 1));
                end
            end else begin
                check("sb_done_idle", 32'(done4), 32'd0);
            end
        end
    end

    task automatic run_until_done4(input int budget);
        int  i;
        logic seen;
        i    = 0;
        seen = 1'b0;
        while (!seen && i < budget) begin
            @(negedge clk);
            if (done4 === 1'b1) seen = 1'b1;
            cyc_end();
            i++;
        end
        check("done_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        int   n_en;
        int   i;
        logic seen;

        // Reset with a kick asserted: the kick must be ignored
        reset4 = 1'b1; kick4 = 1'b1; en4 = 1'b1;
        reset1 = 1'b1; kick1 = 1'b1; en1 = 1'b1;
        repeat (3) cyc_end();
        reset4 = 1'b0; kick4 = 1'b0;
        reset1 = 1'b0; kick1 = 1'b0;

        // Idle: no kick for 10 cycles
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_addr",  32'(addr4),  32'd0);
            check("idle_busy",  32'(busy4),  32'd0);
            check("idle_valid", 32'(valid4), 32'd0);
            check("idle_done",  32'(done4),  32'd0);
            cyc_end();
        end

        // Full frame with enable held high
        kick4 = 1'b1; en4 = 1'b1;
        push_frame();
        @(negedge clk);
        check("kick_cycle_busy", 32'(busy4), 32'd0);
        cyc_end();
        kick4 = 1'b0;
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            check("delay_busy",  32'(busy4),  32'd1);
            check("delay_valid", 32'(valid4), 32'd0);
            cyc_end();
        end
        for (int k = 0; k < c_w4; k++) begin
            @(negedge clk);
            check("addr_valid", 32'(valid4), 32'd1);
            check("addr_busy",  32'(busy4),  32'd1);
            check("addr_value", 32'(addr4),  32'(k));
            cyc_end();
        end
        @(negedge clk);
        check("post_done_busy",  32'(busy4),  32'd0);
        check("post_done_addr",  32'(addr4),  32'd0);
        check("post_done_valid", 32'(valid4), 32'd0);
        check("sb_empty_1", 32'(exp_q.size()), 32'd0);
        cyc_end();
        repeat (2) cyc_end();

        // Toggling enable, stray kicks during DELAY and ADDRESSING
        kick4 = 1'b1; en4 = 1'b0;
        push_frame();
        @(negedge clk);
        check("kick2_busy", 32'(busy4), 32'd0);
        cyc_end();
        for (int d = 0; d < 4; d++) begin
            kick4 = (d == 1);
            en4   = 1'b1;
            @(negedge clk);
            check("delay2_busy",  32'(busy4),  32'd1);
            check("delay2_valid", 32'(valid4), 32'd0);
            cyc_end();
        end
        n_en = 0; i = 0; seen = 1'b0;
        while (!seen && i < 60) begin
            en4   = (i % 2 == 0);
            kick4 = (i % 5 == 3);
            @(negedge clk);
            check("valid_follows_en", 32'(valid4), 32'(en4));
            if (en4) n_en++;
            if (done4 === 1'b1) seen = 1'b1;
            cyc_end();
            i++;
        end
        check("toggle_done_seen", 32'(seen), 32'd1);
        check("toggle_en_count",  32'(n_en), 32'd16);

        // Back-to-back restart on the READY cycle after done
        kick4 = 1'b1; en4 = 1'b0;
        push_frame();
        @(negedge clk);
        check("restart_ready_busy", 32'(busy4), 32'd0);
        cyc_end();
        kick4 = 1'b0; en4 = 1'b1;
        @(negedge clk);
        check("restart_delay_busy",  32'(busy4),  32'd1);
        check("restart_delay_valid", 32'(valid4), 32'd0);
        cyc_end();
        repeat (3) cyc_end();
        // Addresses 0..5, then reset while the 7th address is presented
        repeat (6) cyc_end();
        reset4 = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("seventh_addr", 32'(addr4), 32'd6);
        cyc_end();
        reset4 = 1'b0;
        @(negedge clk);
        check("after_reset_busy",  32'(busy4),  32'd0);
        check("after_reset_addr",  32'(addr4),  32'd0);
        check("after_reset_valid", 32'(valid4), 32'd0);
        cyc_end();

        // Restart after mid-frame reset begins again at address 0
        kick4 = 1'b1; en4 = 1'b1;
        push_frame();
        cyc_end();
        kick4 = 1'b0;
        run_until_done4(40);
        @(negedge clk);
        check("sb_empty_2", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(busy4), 32'd0);
        cyc_end();

        // Single partition: one DELAY cycle, first address at t+2
        kick1 = 1'b1; en1 = 1'b1;
        @(negedge clk);
        check("p1_kick_busy", 32'(busy1), 32'd0);
        cyc_end();
        kick1 = 1'b0;
        @(negedge clk);
        check("p1_delay_busy",  32'(busy1),  32'd1);
        check("p1_delay_valid", 32'(valid1), 32'd0);
        cyc_end();
        for (int k = 0; k < c_w1; k++) begin
            @(negedge clk);
            check("p1_valid", 32'(valid1), 32'd1);
            check("p1_addr",  32'(addr1),  32'(k));
            check("p1_done",  32'(done1),  32'(k == c_w1 - 1));
            cyc_end();
        end
        @(negedge clk);
        check("p1_idle_busy", 32'(busy1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_def
`default_nettype wire
